// File: rtl/xood_pkg.sv
// Shared types and constants for the xoodyak result egress path.
// Imported by the serializer and the unloader top.
package xood_pkg;

  localparam int XOOD_BLK_W  = 128;
  localparam int XOOD_WORD_W = 32;

  localparam logic KIND_TEXT = 1'b0;
  localparam logic KIND_TAG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND_TXT,
    SEND_TAG
  } state_t;

endpackage

// File: rtl/xood_blk_serializer.sv
// Holds one block and presents it MS word first over valid/ready.
// A load restarts at word 0 and may arrive on the final transfer.
module xood_blk_serializer
  import xood_pkg::*;
#(
  parameter int BLK_W  = XOOD_BLK_W,
  parameter int WORD_W = XOOD_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_vld,
  input  logic [BLK_W-1:0]  blk_in,
  input  logic              rdy,
  output logic              vld,
  output logic [WORD_W-1:0] data,
  output logic              fire,
  output logic              last
);

  localparam int NWORDS = BLK_W / WORD_W;
  localparam int IW     = $clog2(NWORDS);

  logic [BLK_W-1:0] blk_q;
  logic [IW-1:0]    idx_q;
  logic             vld_q;

  assign vld  = vld_q;
  assign fire = vld_q & rdy;
  assign last = (idx_q == IW'(NWORDS - 1));

  always_comb begin
    data = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == i[IW-1:0]) begin
        data = blk_q[BLK_W-1-WORD_W*i -: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else if (load) begin
      blk_q <= blk_in;
      idx_q <= '0;
      vld_q <= load_vld;
    end else if (fire) begin
      if (last) begin
        vld_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xood_result_unloader.sv
// Captures xoodyak results on completion and streams text then tag.
// Decryption checks the tag first and suppresses text on mismatch.
module xood_result_unloader
  import xood_pkg::*;
#(
  parameter int BLK_W  = XOOD_BLK_W,
  parameter int WORD_W = XOOD_WORD_W
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic              encdone,
  input  logic              opmode,
  input  logic [BLK_W-1:0]  textout,
  input  logic [BLK_W-1:0]  authdata,
  input  logic [BLK_W-1:0]  exp_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_kind,
  output logic              out_last,
  output logic              busy,
  output logic              tag_ok,
  output logic              tag_fail,
  output logic              overrun
);

  state_t           state_q;
  state_t           state_d;
  logic             encdone_q;
  logic             mode_q;
  logic [BLK_W-1:0] tag_q;

  logic             ev;
  logic             match;
  logic             ser_load;
  logic             ser_load_vld;
  logic [BLK_W-1:0] ser_blk;
  logic             ser_vld;
  logic             ser_fire;
  logic             ser_last;
  logic             tag_ok_d;
  logic             tag_fail_d;

  assign ev    = encdone & ~encdone_q;
  assign match = (authdata == exp_tag);

  xood_blk_serializer #(
    .BLK_W (BLK_W),
    .WORD_W(WORD_W)
  ) u_ser (
    .clk     (eph1),
    .rst_n   (reset),
    .load    (ser_load),
    .load_vld(ser_load_vld),
    .blk_in  (ser_blk),
    .rdy     (out_ready),
    .vld     (ser_vld),
    .data    (out_data),
    .fire    (ser_fire),
    .last    (ser_last)
  );

  always_comb begin
    state_d      = state_q;
    ser_load     = 1'b0;
    ser_load_vld = 1'b0;
    ser_blk      = textout;
    tag_ok_d     = 1'b0;
    tag_fail_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev) begin
          ser_load = 1'b1;
          if (!opmode || match) begin
            state_d      = SEND_TXT;
            ser_load_vld = 1'b1;
            tag_ok_d     = opmode;
          end else begin
            // failed tag: scrub the plaintext, emit nothing
            ser_blk    = '0;
            tag_fail_d = 1'b1;
          end
        end
      end
      SEND_TXT: begin
        if (ser_fire && ser_last) begin
          if (mode_q) begin
            state_d = IDLE;
          end else begin
            state_d      = SEND_TAG;
            ser_load     = 1'b1;
            ser_load_vld = 1'b1;
            ser_blk      = tag_q;
          end
        end
      end
      SEND_TAG: begin
        if (ser_fire && ser_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eph1) begin
    if (!reset) begin
      state_q   <= IDLE;
      encdone_q <= 1'b0;
      mode_q    <= 1'b0;
      tag_q     <= '0;
      tag_ok    <= 1'b0;
      tag_fail  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      encdone_q <= encdone;
      tag_ok    <= tag_ok_d;
      tag_fail  <= tag_fail_d;
      if (ev && state_q != IDLE) begin
        overrun <= 1'b1;
      end
      if (ev && state_q == IDLE) begin
        mode_q <= opmode;
        tag_q  <= authdata;
      end
    end
  end

  assign out_valid = ser_vld;
  assign busy      = (state_q != IDLE);
  assign out_kind  = (state_q == SEND_TAG) ? KIND_TAG : KIND_TEXT;
  assign out_last  = ser_vld & ser_last &
                     ((state_q == SEND_TAG) |
                      ((state_q == SEND_TXT) & mode_q));

endmodule

// File: doc/xood_result_unloader.md
Name: xood_result_unloader

Overview:
- Output-side counterpart to the stimulus driver of xoodyaktop: consumes the core's completion event and results (textout, authdata).
- Streams results to the host as 32-bit words over a valid/ready interface.
- In decryption mode, checks the computed tag against the host-supplied expected tag and withholds plaintext on mismatch.
- Sits between xoodyaktop and the host/bus egress.

Parameters:
- BLK_W, 128, width of textout, authdata and exp_tag.
- WORD_W, 32, egress word width; BLK_W must be a multiple of WORD_W.
- NWORDS, BLK_W/WORD_W (4), words per block; derived, not overridable.

Ports:
- eph1  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset: 0 = reset.
- encdone  in  1  core completion; level-tolerant, the rising edge is the event.
- opmode  in  1  0 = encryption, 1 = decryption; sampled at capture.
- textout  in  BLK_W  ciphertext (enc) or plaintext (dec) from core.
- authdata  in  BLK_W  computed tag from core.
- exp_tag  in  BLK_W  expected tag for decryption; sampled at capture.
- out_valid  out  1  egress word valid.
- out_ready  in  1  egress sink ready.
- out_data  out  WORD_W  egress word.
- out_kind  out  1  0 = text word, 1 = tag word.
- out_last  out  1  final word of the current transaction.
- busy  out  1  high in any state other than IDLE.
- tag_ok  out  1  one-cycle pulse: decryption tag matched.
- tag_fail  out  1  one-cycle pulse: decryption tag mismatched.
- overrun  out  1  sticky: a completion event arrived while busy.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE; word index = 0; encdone edge register = 0.
  - All outputs = 0; capture registers = 0.
  - Applies mid-stream: the current transaction is abandoned, no out_last is issued, overrun is cleared.
- Event: ev = encdone & ~encdone_q, where encdone_q is registered every cycle.
- IDLE:
  - On ev at edge N, capture txt = textout, tag = authdata, mode = opmode, match = (authdata == exp_tag).
  - Transition at N+1:
    - mode=0 -> SEND_TXT.
    - mode=1 & match -> SEND_TXT; tag_ok=1 for cycle N+1 only.
    - mode=1 & ~match -> IDLE; tag_fail=1 for cycle N+1 only; no words emitted; txt register cleared to 0.
- SEND_TXT:
  - out_valid=1, out_kind=0, out_data = txt word [BLK_W-1-32*idx -: 32]; MS word first.
  - idx advances only when out_valid & out_ready.
  - After word NWORDS-1 transfers: enc -> SEND_TAG with idx=0; dec -> IDLE.
  - out_last=1 on word NWORDS-1 in decryption only.
- SEND_TAG (enc only):
  - Same word ordering from tag, out_kind=1.
  - out_last=1 on word NWORDS-1; on its transfer -> IDLE.
- Handshake:
  - While out_valid & ~out_ready, out_data/out_kind/out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
  - Throughput is 1 word/cycle with out_ready held high.
- Latency:
  - First word valid at N+1.
  - Encryption with ready=1: last tag word transfers at N+8, busy drops at N+9.
  - Decryption with match and ready=1: last word transfers at N+4, busy drops at N+5.
- Overrun:
  - ev while busy sets overrun (sticky until reset); the new results are dropped.
  - The in-flight transaction continues unaffected.
- ev in the same cycle busy returns to IDLE (final transfer cycle) counts as overrun; the capture is taken only when state==IDLE at the edge.
- busy is low in IDLE, including the tag_fail cycle.

Decomposition:
- Shared package xood_pkg:
  - state enum {IDLE, SEND_TXT, SEND_TAG}.
  - KIND_TEXT=0, KIND_TAG=1.
  - XOOD_BLK_W=128, XOOD_WORD_W=32.
- One sub-module: xood_blk_serializer. Holds a BLK_W block, a 2-bit index, and valid/ready output. Instantiated once, reloaded with txt then tag.
- Use existing rregs/mux primitives for registers.

Test Plan:
- Encrypt, ready=1: textout=0011223344556677_8899aabbccddeeff, authdata=deadbeef_cafef00d_01234567_89abcdef, encdone pulse at N.
  -> N+1..N+8 words 00112233, 44556677, 8899aabb, ccddeeff (kind 0), then deadbeef, cafef00d, 01234567, 89abcdef (kind 1).
  -> out_last only on 89abcdef; busy low at N+9.
- Decrypt, match: opmode=1, exp_tag=authdata.
  -> tag_ok pulse at N+1; 4 text words only, out_last on ccddeeff; tag_fail never asserts.
- Decrypt, mismatch: exp_tag differs in bit 0.
  -> tag_fail pulse at N+1; out_valid stays 0 throughout; busy stays 0.
- Backpressure: encrypt with out_ready low for 3 cycles on word idx 1 and word idx 6.
  -> data held stable (44556677, then 01234567); no word lost or duplicated; total 8 transfers.
- Overrun: second encdone rising edge at N+3 during an encrypt.
  -> overrun=1 from N+4, sticky; first stream completes unchanged; no second stream.
  -> encdone held high for 10 cycles produces exactly one transaction.
- Reset mid-stream: reset=0 for one cycle at N+5.
  -> next cycle all outputs 0, state IDLE, overrun 0.
  -> a new encdone edge then yields a full 8-word stream.
